// File: rtl/sv_collector.sv
// ---------------------------------------------------------------------------
// sv_collector
//   Buffers the support vectors produced by an SVM trainer, then streams them
//   to a classifier. Each trainer beat carries one sample: {alpha, x, y}.
//   Beats are stored in arrival order with alpha clamped to C_VAL. The last
//   beat of a run carries in_done. When that beat arrives, the stored entries
//   are replayed in index order over a valid/ready read port.
//
//   Optional feature (compile-time macro SV_ZERO_FILTER_EN):
//     defined   - beats with alpha == 0 are accepted but not stored
//     undefined - every accepted beat is stored
//
// Parameters
//   DEPTH  number of buffer entries (at most 63, limited by sv_count width)
//   DW     width of alpha and x
//   C_VAL  upper bound applied to stored alpha
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   in_valid/in_ready    trainer beat handshake
//   in_alpha, in_x, in_y sample payload (alpha unsigned, x/y two's complement)
//   in_done              last trainer beat, qualified by in_valid
//   out_valid/out_ready  classifier read handshake
//   out_alpha/x/y        stored entry being presented
//   out_last             presented entry is the final stored one
//   sv_count             number of stored entries
//   overflow             sticky: a storable beat was dropped because the
//                        buffer was full
//   busy                 collecting or draining
// ---------------------------------------------------------------------------
module sv_collector #(
    parameter int unsigned DEPTH = 50,
    parameter int unsigned DW    = 9,
    parameter int unsigned C_VAL = 20
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_alpha,
    input  logic [DW-1:0] in_x,
    input  logic [1:0]    in_y,
    input  logic          in_done,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_alpha,
    output logic [DW-1:0] out_x,
    output logic [1:0]    out_y,
    output logic          out_last,
    output logic [5:0]    sv_count,
    output logic          overflow,
    output logic          busy
);

    localparam int unsigned CW    = 6;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  Y_POS = 2'b01;

    typedef struct packed {
        logic [DW-1:0] alpha;
        logic [DW-1:0] x;
        logic [1:0]    y;
    } sv_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    sv_entry_t       mem [DEPTH];
    sv_entry_t       rd_entry;
    logic [AW-1:0]   rd_idx;

    // Control strobes from the next-state logic
    logic            accept;
    logic            clear;
    logic            load;
    logic [AW-1:0]   load_idx;
    logic            finish;

    // Write-side datapath
    logic            qualify;
    logic [CW-1:0]   count_base;
    logic            room;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [DW-1:0]   alpha_clamp;

    // Storage qualification
`ifdef SV_ZERO_FILTER_EN
    assign qualify = (in_alpha != '0);
`else
    assign qualify = 1'b1;
`endif

    // A first beat in IDLE starts a fresh run, so count from zero
    assign count_base  = clear ? '0 : sv_count;
    assign room        = (count_base < CW'(DEPTH));
    assign wr_en       = accept & qualify & room;
    assign wr_idx      = AW'(count_base);
    assign alpha_clamp = (in_alpha > DW'(C_VAL)) ? DW'(C_VAL) : in_alpha;
    assign rd_entry    = mem[load_idx];

    // State register plus registered in_ready/busy decoded from next state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != DRAIN);
            busy     <= (state_next != IDLE);
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        load_idx   = '0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    clear      = 1'b1;
                    state_next = in_done ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_done) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!out_valid) begin
                    // First drain cycle: prime the read register, or leave
                    // straight away when nothing was stored
                    if (sv_count == '0) begin
                        state_next = IDLE;
                    end else begin
                        load     = 1'b1;
                        load_idx = '0;
                    end
                end else if (out_ready) begin
                    if (out_last) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load     = 1'b1;
                        load_idx = rd_idx + AW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Buffer storage; contents are only meaningful below sv_count
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= '{alpha: alpha_clamp, x: in_x, y: in_y};
        end
    end

    // Count, overflow flag and registered read port
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sv_count  <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_alpha <= '0;
            out_x     <= '0;
            out_y     <= Y_POS;
            rd_idx    <= '0;
        end else begin
            if (accept) begin
                sv_count <= (qualify && room) ? count_base + CW'(1) : count_base;
                if (qualify && !room) begin
                    overflow <= 1'b1;
                end else if (clear) begin
                    overflow <= 1'b0;
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_alpha <= rd_entry.alpha;
                out_x     <= rd_entry.x;
                out_y     <= rd_entry.y;
                out_last  <= (CW'(load_idx) == sv_count - CW'(1));
                rd_idx    <= load_idx;
            end else if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sv_collector.sv
// ---------------------------------------------------------------------------
// tb_sv_collector
//   Directed bench for sv_collector. A transaction-level model (a queue of
//   stored entries plus a phase) predicts every output each cycle; directed
//   scenarios add hand-computed literal expectations. Works with or without
//   SV_ZERO_FILTER_EN defined.
// ---------------------------------------------------------------------------
module tb_sv_collector;

    localparam int DEPTH = 50;
    localparam int DW    = 9;
    localparam int C_VAL = 20;
    localparam int MAX_DRAIN = 300;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_DRAIN   = 2;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic [DW-1:0] in_alpha;
    logic [DW-1:0] in_x;
    logic [1:0]    in_y;
    logic          in_done;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_alpha;
    logic [DW-1:0] out_x;
    logic [1:0]    out_y;
    logic          out_last;
    logic [5:0]    sv_count;
    logic          overflow;
    logic          busy;

    sv_collector #(.DEPTH(DEPTH), .DW(DW), .C_VAL(C_VAL)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_alpha  (in_alpha),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_done   (in_done),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_alpha (out_alpha),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .sv_count  (sv_count),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] x;
        logic [1:0]    y;
    } ent_t;

    ent_t m_q[$];
    int   m_phase = P_IDLE;
    bit   m_ovf   = 1'b0;
    bit   m_vld   = 1'b0;
    int   m_idx   = 0;

    function automatic bit stores(input logic [DW-1:0] a);
`ifdef SV_ZERO_FILTER_EN
        return (a != 0);
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        ent_t e;
        if (!resetn) begin
            m_phase = P_IDLE;
            m_q.delete();
            m_ovf = 1'b0;
            m_vld = 1'b0;
            m_idx = 0;
        end else if (m_phase != P_DRAIN) begin
            if (in_valid) begin
                if (m_phase == P_IDLE) begin
                    m_q.delete();
                    m_ovf = 1'b0;
                end
                if (stores(in_alpha)) begin
                    if (m_q.size() < DEPTH) begin
                        e.a = (in_alpha > DW'(C_VAL)) ? DW'(C_VAL) : in_alpha;
                        e.x = in_x;
                        e.y = in_y;
                        m_q.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                m_phase = in_done ? P_DRAIN : P_COLLECT;
            end
        end else begin
            if (!m_vld) begin
                if (m_q.size() == 0) m_phase = P_IDLE;
                else begin
                    m_vld = 1'b1;
                    m_idx = 0;
                end
            end else if (out_ready) begin
                if (m_idx == m_q.size() - 1) begin
                    m_vld   = 1'b0;
                    m_phase = P_IDLE;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  32'(in_ready),  32'(m_phase != P_DRAIN));
            chk("busy",      32'(busy),      32'(m_phase != P_IDLE));
            chk("sv_count",  32'(sv_count),  32'(m_q.size()));
            chk("overflow",  32'(overflow),  32'(m_ovf));
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            if (m_vld) begin
                chk("out_alpha", 32'(out_alpha), 32'(m_q[m_idx].a));
                chk("out_x",     32'(out_x),     32'(m_q[m_idx].x));
                chk("out_y",     32'(out_y),     32'(m_q[m_idx].y));
                chk("out_last",  32'(out_last),  32'(m_idx == m_q.size() - 1));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int rec_a[$];
    int rec_x[$];
    int rec_y[$];
    int rec_last[$];
    int busy_cycles;
    bit any_valid;

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] x,
                        input logic [1:0] y, input bit d);
        in_valid = 1'b1;
        in_alpha = a;
        in_x     = x;
        in_y     = y;
        in_done  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_done  = 1'b0;
    endtask

    // Drain with an optional out_ready stall window; poke drives junk beats
    // on the trainer port while draining
    task automatic drain(input int stall_from, input int stall_len, input bit poke);
        bit fin = 1'b0;
        rec_a.delete();
        rec_x.delete();
        rec_y.delete();
        rec_last.delete();
        busy_cycles = 0;
        any_valid   = 1'b0;
        for (int cyc = 0; cyc < MAX_DRAIN && !fin; cyc++) begin
            out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            if (poke) begin
                in_valid = 1'b1;
                in_alpha = 9'd7;
                in_x     = 9'd3;
                in_y     = 2'b01;
                in_done  = 1'b1;
            end
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (out_valid === 1'b1) any_valid = 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                rec_a.push_back(int'(out_alpha));
                rec_x.push_back(int'(out_x));
                rec_y.push_back(int'(out_y));
                rec_last.push_back(int'(out_last));
            end
            if (m_phase == P_IDLE) begin
                fin      = 1'b1;
                in_valid = 1'b0;
                in_done  = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!fin) chk("drain_timeout", 32'(0), 32'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int exp35[$];
        int exp39_n;
        int exp39_busy;
        bit ok;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_alpha  = '0;
        in_x      = '0;
        in_y      = 2'b01;
        in_done   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset values
        chk("rst_in_ready",  32'(in_ready),  32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_last",  32'(out_last),  32'(0));
        chk("rst_out_alpha", 32'(out_alpha), 32'(0));
        chk("rst_out_x",     32'(out_x),     32'(0));
        chk("rst_out_y",     32'(out_y),     32'(1));
        chk("rst_sv_count",  32'(sv_count),  32'(0));
        chk("rst_overflow",  32'(overflow),  32'(0));
        chk("rst_busy",      32'(busy),      32'(0));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Clamp: alpha 30 -> 20, x -7, y -1 kept
        send(9'd30, 9'h1F9, 2'b11, 1'b1);
        drain(0, 0, 1'b0);
        chk("clamp_n",     32'(rec_a.size()), 32'(1));
        if (rec_a.size() == 1) begin
            chk("clamp_alpha", 32'(rec_a[0]),    32'(20));
            chk("clamp_x",     32'(rec_x[0]),    32'(9'h1F9));
            chk("clamp_y",     32'(rec_y[0]),    32'(2'b11));
            chk("clamp_last",  32'(rec_last[0]), 32'(1));
        end
        chk("clamp_count", 32'(sv_count), 32'(1));

        // Zero-alpha filtering with a 4-cycle out_ready stall
`ifdef SV_ZERO_FILTER_EN
        exp35 = '{5, 1, 20};
`else
        exp35 = '{0, 5, 1, 20, 0};
`endif
        send(9'd0,  9'd1, 2'b01, 1'b0);
        send(9'd5,  9'd2, 2'b01, 1'b0);
        send(9'd1,  9'd3, 2'b01, 1'b0);
        send(9'd20, 9'd4, 2'b01, 1'b0);
        send(9'd0,  9'd5, 2'b01, 1'b1);
        chk("filt_count", 32'(sv_count), 32'(exp35.size()));
        drain(1, 4, 1'b0);
        chk("filt_n", 32'(rec_a.size()), 32'(exp35.size()));
        if (rec_a.size() == exp35.size()) begin
            foreach (exp35[i]) begin
                chk("filt_alpha", 32'(rec_a[i]), 32'(exp35[i]));
                chk("filt_last",  32'(rec_last[i]), 32'(i == exp35.size() - 1));
            end
        end

        // Unusual labels stored as-is; trainer beats during drain ignored
        send(9'd3,  9'd4,   2'b00, 1'b0);
        send(9'd25, 9'h1FF, 2'b10, 1'b1);
        drain(0, 0, 1'b1);
        chk("lab_n", 32'(rec_a.size()), 32'(2));
        if (rec_a.size() == 2) begin
            chk("lab_a0", 32'(rec_a[0]), 32'(3));
            chk("lab_y0", 32'(rec_y[0]), 32'(0));
            chk("lab_a1", 32'(rec_a[1]), 32'(20));
            chk("lab_x1", 32'(rec_x[1]), 32'(9'h1FF));
            chk("lab_y1", 32'(rec_y[1]), 32'(2));
        end
        chk("lab_count", 32'(sv_count), 32'(2));

        // All-zero alphas
`ifdef SV_ZERO_FILTER_EN
        exp39_n    = 0;
        exp39_busy = 1;
`else
        exp39_n    = 3;
        exp39_busy = 4;
`endif
        send(9'd0, 9'd1, 2'b01, 1'b0);
        send(9'd0, 9'd2, 2'b11, 1'b0);
        send(9'd0, 9'd3, 2'b01, 1'b1);
        drain(0, 0, 1'b0);
        chk("zero_n",        32'(rec_a.size()), 32'(exp39_n));
        chk("zero_busy",     32'(busy_cycles),  32'(exp39_busy));
        chk("zero_anyvalid", 32'(any_valid),    32'(exp39_n != 0));
        chk("zero_count",    32'(sv_count),     32'(exp39_n));

        // Overflow: DEPTH+3 nonzero beats
        for (int i = 0; i < DEPTH + 3; i++) begin
            send(DW'((i % 20) + 1), DW'(i), 2'b01, i == DEPTH + 2);
            if (i == DEPTH - 1) begin
                chk("ovf_full_count", 32'(sv_count), 32'(50));
                chk("ovf_full_flag",  32'(overflow), 32'(0));
            end
            if (i == DEPTH) begin
                chk("ovf_set_count", 32'(sv_count), 32'(50));
                chk("ovf_set_flag",  32'(overflow), 32'(1));
            end
        end
        drain(0, 0, 1'b0);
        chk("ovf_n", 32'(rec_a.size()), 32'(50));
        if (rec_a.size() == 50) begin
            for (int i = 0; i < 50; i++) begin
                chk("ovf_alpha", 32'(rec_a[i]), 32'((i % 20) + 1));
                chk("ovf_x",     32'(rec_x[i]), 32'(i));
            end
            chk("ovf_last", 32'(rec_last[49]), 32'(1));
        end
        chk("ovf_hold", 32'(overflow), 32'(1));

        // Reset pulse in the middle of a drain
        send(9'd2, 9'd10, 2'b01, 1'b0);
        send(9'd4, 9'd11, 2'b01, 1'b0);
        send(9'd6, 9'd12, 2'b01, 1'b0);
        send(9'd8, 9'd13, 2'b01, 1'b1);
        out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ok = 1'b1;
        end
        chk("mid_valid_seen", 32'(ok), 32'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("mid_second_alpha", 32'(out_alpha), 32'(4));
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_in_ready",  32'(in_ready),  32'(1));
        chk("mid_out_valid", 32'(out_valid), 32'(0));
        chk("mid_out_last",  32'(out_last),  32'(0));
        chk("mid_out_alpha", 32'(out_alpha), 32'(0));
        chk("mid_out_x",     32'(out_x),     32'(0));
        chk("mid_out_y",     32'(out_y),     32'(1));
        chk("mid_sv_count",  32'(sv_count),  32'(0));
        chk("mid_overflow",  32'(overflow),  32'(0));
        chk("mid_busy",      32'(busy),      32'(0));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Normal operation after the aborted drain
        send(9'd9, 9'd1, 2'b11, 1'b1);
        drain(0, 0, 1'b0);
        chk("post_n", 32'(rec_a.size()), 32'(1));
        if (rec_a.size() == 1) chk("post_alpha", 32'(rec_a[0]), 32'(9));

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sv_collector.md
SV_COLLECTOR -- requirements
Module: sv_collector

Interface
REQ-001 Parameter DEPTH, default 50, support-vector buffer entries.
REQ-002 Parameter DW, default 9, data width of alpha and x.
REQ-003 Parameter C_VAL, default 20, alpha upper bound (box constraint).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  trainer result beat valid.
REQ-007 in_alpha  input  DW  unsigned alpha of the current sample.
REQ-008 in_x  input  DW  signed sample value.
REQ-009 in_y  input  2  signed label, +1 or -1.
REQ-010 in_done  input  1  trainer finished; qualified by in_valid.
REQ-011 in_ready  output  1  collector accepts beats.
REQ-012 out_valid  output  1  classifier read beat valid.
REQ-013 out_ready  input  1  classifier accepts read beat.
REQ-014 out_alpha / out_x / out_y  output  DW / DW / 2  stored support vector.
REQ-015 out_last  output  1  marks final stored entry.
REQ-016 sv_count  output  6  number of stored entries.
REQ-017 overflow  output  1  sticky, a qualifying beat was dropped because the buffer was full.
REQ-018 busy  output  1  high in COLLECT or DRAIN.

Function
REQ-019 FSM states: IDLE, COLLECT, DRAIN.
REQ-020 Beat accepted on in_valid & in_ready; in_ready = 1 in IDLE and COLLECT, 0 in DRAIN.
REQ-021 Accepted beat in IDLE: clear sv_count and overflow, store the beat, go to COLLECT.
REQ-022 Qualifying beat with sv_count < DEPTH: write {min(in_alpha, C_VAL), in_x, in_y} at index sv_count, increment sv_count next cycle.
REQ-023 Qualifying beat with sv_count == DEPTH: no write, set overflow, hold sv_count.
REQ-024 in_done on an accepted beat: store the beat first, then go to DRAIN next cycle.
REQ-025 DRAIN: registered read; out_valid rises 1 cycle after entering DRAIN; entries emitted in index order 0..sv_count-1.
REQ-026 out_* stable while out_valid & !out_ready; next entry presented the cycle after each handshake.
REQ-027 out_last = 1 with entry sv_count-1; its handshake returns the FSM to IDLE; sv_count and overflow held.
REQ-028 DRAIN with sv_count == 0: out_valid never asserts; return to IDLE after 1 cycle.
REQ-029 in_valid during DRAIN ignored, no state change.
REQ-030 in_y other than +1/-1 stored unchanged, not flagged.

Reset
REQ-031 resetn low: FSM to IDLE; in_ready = 1; out_valid = 0, out_last = 0, out_alpha = 0, out_x = 0, out_y = +1; sv_count = 0; overflow = 0; busy = 0.
REQ-032 Reset mid-COLLECT or mid-DRAIN aborts the operation; buffer contents are undefined and never read before being rewritten.

Configuration
REQ-033 Macro SV_ZERO_FILTER_EN defined: only beats with in_alpha != 0 qualify for storage; zero-alpha beats are accepted and discarded.
REQ-034 SV_ZERO_FILTER_EN undefined: every accepted beat qualifies.

Verification
REQ-035 Filter on; beats alpha 0,5,1,20,0 with in_done on the 5th -> sv_count = 3; drain emits alpha 5,1,20; out_last on the 3rd entry.
REQ-036 Beat alpha 30, x -7, y -1 -> stored alpha 20, x -7, y -1.
REQ-037 DEPTH+3 nonzero beats -> sv_count = 50, overflow = 1 after the 51st beat; 50 entries drained.
REQ-038 out_ready held low 4 cycles during DRAIN -> out_* unchanged; no entry skipped or duplicated.
REQ-039 Filter on; all-zero alphas then in_done -> DRAIN 1 cycle, out_valid never 1, IDLE, sv_count = 0.
REQ-040 resetn low for 1 cycle mid-DRAIN -> all outputs at REQ-031 values next cycle.
